// File: rtl/xge_mac_ocp_reg_bridge.sv
// xge_mac_ocp_reg_bridge: OCP slave to xge_mac register-bus bridge, one
// transaction outstanding. Each accepted WR/RD becomes a one-cycle
// regb_wen_o/regb_ren_o strobe. The bridge waits for regb_ack_i and returns
// DVA/ERR on SResp, with read data on SData.
//
// Optional feature: define XGE_MAC_OCP_BRIDGE_TIMEOUT_EN to force an ERR
// response (and pulse timeout_o) after TIMEOUT_CYCLES WAIT cycles with no ack.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   ocp_MCmd_i/MAddr_i/MData_i   OCP request (IDLE/WR/RD, others -> ERR)
//   ocp_SCmdAccept_o             request accepted this cycle (IDLE only)
//   ocp_SResp_o/SData_o          OCP response (NULL/DVA/ERR) and read data
//   ocp_MRespAccept_i            master consumes the response
//   regb_addr_o/wbdata_o         captured address / write data
//   regb_wen_o/ren_o             one-cycle write / read strobes
//   regb_rdata_i/ack_i/error_i   register block reply
//   timeout_o                    one-cycle pulse on a forced timeout
module xge_mac_ocp_reg_bridge #(
    parameter int REG_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [2:0]                ocp_MCmd_i,
    input  logic [REG_ADDR_WIDTH-1:0] ocp_MAddr_i,
    input  logic [REG_DATA_WIDTH-1:0] ocp_MData_i,
    output logic                      ocp_SCmdAccept_o,
    output logic [1:0]                ocp_SResp_o,
    output logic [REG_DATA_WIDTH-1:0] ocp_SData_o,
    input  logic                      ocp_MRespAccept_i,
    output logic [REG_ADDR_WIDTH-1:0] regb_addr_o,
    output logic [REG_DATA_WIDTH-1:0] regb_wbdata_o,
    output logic                      regb_wen_o,
    output logic                      regb_ren_o,
    input  logic [REG_DATA_WIDTH-1:0] regb_rdata_i,
    input  logic                      regb_ack_i,
    input  logic                      error_i,
    output logic                      timeout_o
);

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;

    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                    state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      rd_q, rd_d;
    logic [1:0]                sresp_q, sresp_d;
    logic [REG_DATA_WIDTH-1:0] sdata_q, sdata_d;

`ifdef XGE_MAC_OCP_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tout_q, tout_d;
    logic             tmo_hit;

    // cnt_q counts ack-less WAIT cycles already elapsed, so the match on
    // TIMEOUT_CYCLES-1 fires in the TIMEOUT_CYCLES-th ack-less cycle.
    assign tmo_hit   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_o = tout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // resetn gates accept so that no command is taken during a reset cycle.
    assign ocp_SCmdAccept_o = (state_q == S_IDLE) && resetn;

    assign regb_wen_o    = (state_q == S_REQ) && !rd_q;
    assign regb_ren_o    = (state_q == S_REQ) && rd_q;
    assign regb_addr_o   = addr_q;
    assign regb_wbdata_o = wdata_q;
    assign ocp_SResp_o   = sresp_q;
    assign ocp_SData_o   = sdata_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        sresp_d = sresp_q;
        sdata_d = sdata_q;
`ifdef XGE_MAC_OCP_BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (ocp_MCmd_i == CMD_WR || ocp_MCmd_i == CMD_RD) begin
                    addr_d  = ocp_MAddr_i;
                    wdata_d = ocp_MData_i;
                    rd_d    = (ocp_MCmd_i == CMD_RD);
                    state_d = S_REQ;
                end else if (ocp_MCmd_i != CMD_IDLE) begin
                    // Unsupported command: answer ERR with no bus access.
                    sresp_d = RESP_ERR;
                    sdata_d = '0;
                    state_d = S_RESP;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
`ifdef XGE_MAC_OCP_BRIDGE_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (regb_ack_i) begin
                    sresp_d = error_i ? RESP_ERR : RESP_DVA;
                    sdata_d = (rd_q && !error_i) ? regb_rdata_i : '0;
                    state_d = S_RESP;
                end
`ifdef XGE_MAC_OCP_BRIDGE_TIMEOUT_EN
                else if (tmo_hit) begin
                    sresp_d = RESP_ERR;
                    sdata_d = '0;
                    tout_d  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (ocp_MRespAccept_i) begin
                    sresp_d = RESP_NULL;
                    sdata_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            sresp_q <= RESP_NULL;
            sdata_q <= '0;
`ifdef XGE_MAC_OCP_BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            sresp_q <= sresp_d;
            sdata_q <= sdata_d;
`ifdef XGE_MAC_OCP_BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
`endif
        end
    end

endmodule

// File: tb/tb_xge_mac_ocp_reg_bridge.sv
// tb_xge_mac_ocp_reg_bridge: directed bench for the OCP register bridge
// with a small register-block model and an expected-response queue.
module tb_xge_mac_ocp_reg_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  mcmd;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic        scmdacc;
    logic [1:0]  sresp;
    logic [31:0] sdata;
    logic        mrespacc;
    logic [31:0] raddr;
    logic [31:0] rwdata;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        ack_q;
    logic        err_q;
    logic        inj_ack;
    logic        inj_err;
    logic        tmo;
    logic        ack_en;
    logic [31:0] reg4;

    int compared   = 0;
    int mismatched = 0;
    int wen_cnt    = 0;
    int ren_cnt    = 0;
    int both_cnt   = 0;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    xge_mac_ocp_reg_bridge dut (
        .clk              (clk),
        .resetn           (resetn),
        .ocp_MCmd_i       (mcmd),
        .ocp_MAddr_i      (maddr),
        .ocp_MData_i      (mdata),
        .ocp_SCmdAccept_o (scmdacc),
        .ocp_SResp_o      (sresp),
        .ocp_SData_o      (sdata),
        .ocp_MRespAccept_i(mrespacc),
        .regb_addr_o      (raddr),
        .regb_wbdata_o    (rwdata),
        .regb_wen_o       (wen),
        .regb_ren_o       (ren),
        .regb_rdata_i     (rdata),
        .regb_ack_i       (ack_q | inj_ack),
        .error_i          (err_q | inj_err),
        .timeout_o        (tmo)
    );

    // Register block model: 0x0 reads 4, 0x4 scratch, 0x8 reads 0x808,
    // anything else acks with error. Ack comes the cycle after the strobe.
    always @(posedge clk) begin
        ack_q <= 1'b0;
        err_q <= 1'b0;
        rdata <= 32'h0;
        if (ack_en && (wen || ren)) begin
            ack_q <= 1'b1;
            case (raddr)
                32'h0: rdata <= 32'h0000_0004;
                32'h4: begin
                    if (wen) reg4 <= rwdata;
                    rdata <= reg4;
                end
                32'h8: rdata <= 32'h0000_0808;
                default: err_q <= 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (wen === 1'b1) wen_cnt++;
        if (ren === 1'b1) ren_cnt++;
        if (wen === 1'b1 && ren === 1'b1) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] r, input logic [31:0] d);
        exp_t e;
        e.resp = r;
        e.data = d;
        sb.push_back(e);
    endtask

    // Present a command at a negedge, wait for accept, drop it after the edge.
    task automatic issue(input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
        int n;
        @(negedge clk);
        mcmd  = c;
        maddr = a;
        mdata = d;
        n = 0;
        while (scmdacc !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, {31'h0, scmdacc}, 32'h1);
        @(posedge clk);
        #1;
        mcmd = 3'b000;
    endtask

    // Count cycles after accept until a response shows, then score it.
    task automatic wait_resp(input int lat, input string tag);
        int   k;
        exp_t e;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (sresp === 2'b00 && k < 64);
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.resp = 2'b00;
            e.data = 32'h0;
        end
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_resp"}, {30'h0, sresp}, {30'h0, e.resp});
        chk({tag, "_data"}, sdata, e.data);
    endtask

    initial begin
        int w0;
        int r0;
        int bad;
        resetn   = 1'b0;
        mcmd     = 3'b000;
        maddr    = 32'h0;
        mdata    = 32'h0;
        mrespacc = 1'b1;
        ack_en   = 1'b1;
        inj_ack  = 1'b0;
        inj_err  = 1'b0;
        reg4     = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_accept", {31'h0, scmdacc}, 32'h0);
        chk("rst_sresp", {30'h0, sresp}, 32'h0);
        chk("rst_sdata", sdata, 32'h0);
        chk("rst_addr", raddr, 32'h0);
        chk("rst_wbdata", rwdata, 32'h0);
        chk("rst_strobes", {30'h0, wen, ren}, 32'h0);
        chk("rst_timeout", {31'h0, tmo}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_accept", {31'h0, scmdacc}, 32'h1);

        // RD 0x0
        w0 = wen_cnt;
        r0 = ren_cnt;
        push(2'b01, 32'h4);
        issue(3'b010, 32'h0, 32'h0, "rd0");
        wait_resp(3, "rd0");
        chk("rd0_ren_cycles", ren_cnt - r0, 1);
        chk("rd0_wen_cycles", wen_cnt - w0, 0);

        // WR 0x4 then RD 0x4
        w0 = wen_cnt;
        r0 = ren_cnt;
        push(2'b01, 32'h0);
        issue(3'b001, 32'h4, 32'hDEAD_BEEF, "wr4");
        wait_resp(3, "wr4");
        chk("wr4_wen_cycles", wen_cnt - w0, 1);
        chk("wr4_ren_cycles", ren_cnt - r0, 0);
        push(2'b01, 32'hDEAD_BEEF);
        issue(3'b010, 32'h4, 32'h0, "rd4");
        wait_resp(3, "rd4");

        // Undecoded address, then a normal command
        push(2'b11, 32'h0);
        issue(3'b010, 32'hC, 32'h0, "rdC");
        wait_resp(3, "rdC");
        push(2'b01, 32'h4);
        issue(3'b010, 32'h0, 32'h0, "rd0b");
        wait_resp(3, "rd0b");

        // Unsupported command
        w0 = wen_cnt;
        r0 = ren_cnt;
        push(2'b11, 32'h0);
        issue(3'b011, 32'h0, 32'h0, "bad");
        wait_resp(1, "bad");
        repeat (3) @(negedge clk);
        chk("bad_strobes", (wen_cnt - w0) + (ren_cnt - r0), 0);

        // Stale ack with error while idle: ignored
        inj_ack = 1'b1;
        inj_err = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        inj_err = 1'b0;
        @(negedge clk);
        chk("stale_sresp", {30'h0, sresp}, 32'h0);
        chk("stale_accept", {31'h0, scmdacc}, 32'h1);

        // Response back-pressure with a held WR behind it
        mrespacc = 1'b0;
        push(2'b01, 32'h808);
        issue(3'b010, 32'h8, 32'h0, "rd8");
        mcmd  = 3'b001;
        maddr = 32'h4;
        mdata = 32'h1234_5678;
        wait_resp(3, "rd8");
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (sresp !== 2'b01 || sdata !== 32'h808 || scmdacc !== 1'b0)
                bad++;
            if (i == 5) mrespacc = 1'b1;
            else @(negedge clk);
        end
        chk("hold_stable_cycles", bad, 0);
        @(negedge clk);
        chk("hold_release_sresp", {30'h0, sresp}, 32'h0);
        chk("hold_release_accept", {31'h0, scmdacc}, 32'h1);
        push(2'b01, 32'h0);
        @(posedge clk);
        #1;
        mcmd = 3'b000;
        wait_resp(3, "wr_held");
        push(2'b01, 32'h1234_5678);
        issue(3'b010, 32'h4, 32'h0, "rd4b");
        wait_resp(3, "rd4b");

        // Reset for one edge while in WAIT
        ack_en = 1'b0;
        r0 = ren_cnt;
        issue(3'b010, 32'h8, 32'h0, "rdrst");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_sresp", {30'h0, sresp}, 32'h0);
        chk("mid_rst_sdata", sdata, 32'h0);
        chk("mid_rst_addr", raddr, 32'h0);
        chk("mid_rst_strobes", {30'h0, wen, ren}, 32'h0);
        chk("mid_rst_accept", {31'h0, scmdacc}, 32'h0);
        resetn = 1'b1;
        ack_en = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (sresp !== 2'b00) bad++;
        end
        chk("mid_rst_no_resp", bad, 0);
        chk("mid_rst_one_strobe", ren_cnt - r0, 1);

        // Slave that never acks
        ack_en = 1'b0;
`ifdef XGE_MAC_OCP_BRIDGE_TIMEOUT_EN
        push(2'b11, 32'h0);
        issue(3'b010, 32'h0, 32'h0, "tmo");
        wait_resp(18, "tmo");
        chk("tmo_pulse", {31'h0, tmo}, 32'h1);
        @(negedge clk);
        chk("tmo_pulse_end", {31'h0, tmo}, 32'h0);
        chk("tmo_sresp_clr", {30'h0, sresp}, 32'h0);
`else
        issue(3'b010, 32'h0, 32'h0, "noack");
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (sresp !== 2'b00 || tmo !== 1'b0 || scmdacc !== 1'b0) bad++;
        end
        chk("noack_waits", bad, 0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
`endif
        ack_en = 1'b1;
        push(2'b01, 32'h4);
        issue(3'b010, 32'h0, 32'h0, "final");
        wait_resp(3, "final");
        chk("never_both", both_cnt, 0);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/xge_mac_ocp_reg_bridge.md
Name: xge_mac_ocp_reg_bridge

Overview:
- OCP-slave to register-bus bridge. Sits directly upstream of the xge_mac register block.
- Accepts single OCP posted-address read/write commands and turns each one into a one-cycle regb_wen/regb_ren strobe.
- Waits for the register block's ack/error, then returns the OCP response (DVA/ERR, with read data).
- Strictly one transaction outstanding at a time.

Parameters:
REG_ADDR_WIDTH, 32, width of OCP MAddr and regb_addr_o
REG_DATA_WIDTH, 32, width of OCP data and register data
TIMEOUT_CYCLES, 16, WAIT-state cycles without ack before forced ERR (used only with the optional feature)

Ports:
clk  in  1  single clock; all logic on rising edge
resetn  in  1  reset, synchronous, active-low
ocp_MCmd_i  in  3  OCP command: 3'b000 IDLE, 3'b001 WR, 3'b010 RD, others unsupported
ocp_MAddr_i  in  REG_ADDR_WIDTH  byte address
ocp_MData_i  in  REG_DATA_WIDTH  write data
ocp_SCmdAccept_o  out  1  command accepted this cycle
ocp_SResp_o  out  2  2'b00 NULL, 2'b01 DVA, 2'b11 ERR
ocp_SData_o  out  REG_DATA_WIDTH  read data, valid with DVA on RD
ocp_MRespAccept_i  in  1  master takes the response
regb_addr_o  out  REG_ADDR_WIDTH  register address, held for the whole transaction
regb_wbdata_o  out  REG_DATA_WIDTH  register write data
regb_wen_o  out  1  write strobe, one cycle
regb_ren_o  out  1  read strobe, one cycle
regb_rdata_i  in  REG_DATA_WIDTH  register read data, valid with ack
regb_ack_i  in  1  register block ack
error_i  in  1  register block error, qualified by ack
timeout_o  out  1  one-cycle pulse on a timeout; tied 0 when the feature is compiled out

Behaviour:
- Reset: resetn sampled low at a clk edge forces state IDLE. All registered outputs then read 0: SResp NULL, SData 0, regb_* 0, timeout_o 0.
- SCmdAccept is 0 on every cycle in which resetn is low.
- Reset mid-transaction: the transaction is abandoned, no response is returned, and no further strobe is issued.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - ocp_SCmdAccept_o = 1 (combinational from state). MCmd IDLE: stay.
  - WR/RD: capture MAddr, MData and command; go to REQ.
  - Unsupported MCmd: accept it, issue no register strobe, load SResp = ERR and SData = 0, go to RESP.
- REQ:
  - Exactly one cycle with regb_wen_o (WR) or regb_ren_o (RD) = 1. Never both.
  - Address and data driven from the captured registers; go to WAIT.
- WAIT:
  - Strobes are 0; address and data stay held.
  - On regb_ack_i = 1: SResp = error_i ? ERR : DVA. For RD with DVA, SData = regb_rdata_i; otherwise SData = 0. Go to RESP.
  - The register block acks on the cycle after the strobe, so the first WAIT cycle normally carries the ack.
- RESP:
  - SResp/SData held stable until ocp_MRespAccept_i = 1.
  - In that cycle go to IDLE; SResp and SData return to NULL/0 on the next edge.
- SCmdAccept = 0 in REQ, WAIT and RESP. Commands presented then are not accepted; the master holds them.
- Latency, with a single-cycle-ack slave and MRespAccept held 1:
  - command accepted at edge 0
  - strobe in cycle 1
  - ack in cycle 2
  - SResp visible in cycle 3
  - next command accepted in cycle 4
- Ack while not in WAIT (stale or late ack): ignored, with no state change.
- error_i without ack: ignored.
- Back-to-back commands: the second command waits in IDLE for accept. No overlap, no pipelining.

Optional Feature:
- Macro XGE_MAC_OCP_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter, wide enough for TIMEOUT_CYCLES, clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: SResp = ERR, SData = 0, timeout_o pulses one cycle, go to RESP.
  - An ack in that same cycle takes precedence (normal response, no timeout).
- Undefined: no counter; WAIT lasts until ack indefinitely; timeout_o is constant 0.

Test Plan:
- Reset, then RD at 0x0 -> exactly one regb_ren_o pulse; SResp = DVA and SData = 0x00000004 three cycles after accept.
- WR 0xDEADBEEF to 0x4, then RD 0x4 -> first response DVA with SData 0; second response DVA with SData 0xDEADBEEF; regb_wen_o high exactly one cycle.
- RD at 0xC (undecoded address) -> slave returns ack+error; SResp = ERR, SData = 0; next command accepted normally.
- MCmd = 3'b011 at 0x0 -> accepted, no regb_wen_o/regb_ren_o ever asserted, SResp = ERR one cycle after accept.
- RD 0x8 with MRespAccept held 0 for 5 cycles -> SResp/SData stable for 6 cycles; SCmdAccept 0 throughout while a pending WR is held; WR accepted the cycle after release.
- resetn low for one edge during WAIT -> all outputs 0 next cycle, no response. With the macro defined and ack tied 0: SResp = ERR and timeout_o pulse after 16 WAIT cycles.
